// File: rtl/ahbm_pkg.sv
// Shared types and helpers for the AHB-Lite master engine.
// Optional feature macro: AHBM_WRAP_EN (enables WRAP4/WRAP8 bursts).
package ahbm_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'b000,
    HB_INCR   = 3'b001,
    HB_WRAP4  = 3'b010,
    HB_INCR4  = 3'b011,
    HB_WRAP8  = 3'b100,
    HB_INCR8  = 3'b101,
    HB_WRAP16 = 3'b110,
    HB_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_LAST = 2'b10
  } state_e;

  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Number of beats for a burst code; zero marks a code this engine rejects.
  function automatic logic [3:0] beats_of(input hburst_e burst);
    case (burst)
      HB_SINGLE: beats_of = 4'd1;
      HB_INCR4:  beats_of = 4'd4;
      HB_INCR8:  beats_of = 4'd8;
`ifdef AHBM_WRAP_EN
      HB_WRAP4:  beats_of = 4'd4;
      HB_WRAP8:  beats_of = 4'd8;
`endif
      default:   beats_of = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahbm_addr_gen.sv
// Next-beat address for word bursts: +4, with wrap on a 16/32-byte window
// when AHBM_WRAP_EN is defined.
module ahbm_addr_gen
  import ahbm_pkg::*;
#(
  parameter int ADDR_W = 32
) (
`ifdef AHBM_WRAP_EN
  input  hburst_e           burst,
`endif
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] incr;

  assign incr = addr + ADDR_W'(4);

  // Select incrementing or wrapped address for the following beat.
  always_comb begin
    // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
    next_addr = incr;
`ifdef AHBM_WRAP_EN
    case (burst)
      HB_WRAP4: next_addr = {addr[ADDR_W-1:4], incr[3:0]};
      HB_WRAP8: next_addr = {addr[ADDR_W-1:5], incr[4:0]};
      default:  next_addr = incr;
    endcase
`endif
  end

endmodule

// File: rtl/ahb_lite_master_engine.sv
// AHB-Lite single master: command/write-data/read-data streams to pipelined
// word transfers. Optional feature macro: AHBM_WRAP_EN (WRAP4/WRAP8 support).
module ahb_lite_master_engine
  import ahbm_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter logic [2:0] HSIZE_VAL = HSIZE_WORD
) (
  input  logic              h_clk,
  input  logic              h_rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic              wd_valid,
  input  logic [DATA_W-1:0] wd_data,
  output logic              wd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              done,
  output logic              done_err,
  output logic              h_sel,
  output logic [ADDR_W-1:0] h_addr,
  output logic [1:0]        h_trans,
  output logic              h_write,
  output logic [2:0]        h_burst,
  output logic [2:0]        h_size,
  output logic [DATA_W-1:0] h_wdata,
  input  logic              h_ready,
  input  logic [1:0]        h_resp,
  input  logic [DATA_W-1:0] h_rdata
);

  state_e            state_q, state_n;
  htrans_e           trans_q;
  logic [3:0]        beats_q, cmd_beats;
  logic [2:0]        beat_idx_q;
  logic              dp_valid_q, idle_ok_q;
  logic [DATA_W-1:0] wbuf_q;
  logic [ADDR_W-1:0] next_addr;

  logic in_addr, addr_live, resp_err, dp_err, last_beat;
  logic accept, reject, cancel, abort, adv, adv_mid, adv_last;
  logic busy_now, seq_take, beat_done, done_n;

  assign h_trans = trans_q;
  assign h_size  = HSIZE_VAL;

  assign cmd_beats = beats_of(hburst_e'(cmd_burst));
  assign in_addr   = (state_q == ST_ADDR);
  assign addr_live = (trans_q == HT_NONSEQ) || (trans_q == HT_SEQ);
  assign resp_err  = (h_resp != RESP_OKAY);
  assign dp_err    = dp_valid_q && resp_err;
  assign last_beat = ({1'b0, beat_idx_q} == (beats_q - 4'd1));

  assign accept    = cmd_valid && cmd_ready && (cmd_beats != 4'd0);
  assign reject    = cmd_valid && cmd_ready && (cmd_beats == 4'd0);
  // First error cycle: pull the pipelined address back to IDLE.
  assign cancel    = in_addr && dp_err && !h_ready;
  // Single-cycle error completion: drop the rest of the burst at once.
  assign abort     = in_addr && dp_err && h_ready;
  assign adv       = in_addr && !dp_err && addr_live && h_ready;
  assign adv_mid   = adv && !last_beat;
  assign adv_last  = adv && last_beat;
  assign busy_now  = in_addr && !dp_err && (trans_q == HT_BUSY);
  assign seq_take  = h_write && wd_valid && (adv_mid || busy_now);
  assign beat_done = (state_q != ST_IDLE) && dp_valid_q && h_ready;
  assign done_n    = ((state_q == ST_LAST) && h_ready) || abort || reject;

  ahbm_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
`ifdef AHBM_WRAP_EN
    .burst     (hburst_e'(h_burst)),
`endif
    .addr      (h_addr),
    .next_addr (next_addr)
  );

  // State register.
  always_ff @(posedge h_clk or negedge h_rstn) begin
    if (!h_rstn) state_q <= ST_IDLE;
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    else         state_q <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_n = ST_ADDR;
      ST_ADDR: begin
        if (abort)                  state_n = ST_IDLE;
        else if (cancel || adv_last) state_n = ST_LAST;
      end
      ST_LAST: if (h_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Handshake outputs; idle_ok_q keeps cmd_ready low in reset and in the done cycle.
  always_comb begin
    cmd_ready = idle_ok_q && (!cmd_write || wd_valid);
    wd_ready  = (cmd_ready && cmd_valid && (cmd_beats != 4'd0) && cmd_write) || seq_take;
  end

  // Bus-side and stream-side registers.
  always_ff @(posedge h_clk or negedge h_rstn) begin
    if (!h_rstn) begin
      trans_q    <= HT_IDLE;
      h_sel      <= 1'b0;
      h_addr     <= '0;
      h_write    <= 1'b0;
      h_burst    <= 3'b000;
      h_wdata    <= '0;
      wbuf_q     <= '0;
      beats_q    <= 4'd0;
      beat_idx_q <= 3'd0;
      dp_valid_q <= 1'b0;
      idle_ok_q  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_err     <= 1'b0;
      done       <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      idle_ok_q <= (state_n == ST_IDLE) && !done_n;
      done      <= done_n;
      done_err  <= ((state_q == ST_LAST) && h_ready && resp_err) || abort || reject;
      rd_valid  <= beat_done && !h_write;
      rd_err    <= beat_done && resp_err;
      if (beat_done && !h_write) rd_data <= h_rdata;

      if (state_q != ST_IDLE && h_ready) dp_valid_q <= adv;

      if (accept) begin
        trans_q    <= HT_NONSEQ;
        h_sel      <= 1'b1;
        h_addr     <= cmd_addr;
        h_write    <= cmd_write;
        h_burst    <= cmd_burst;
        beats_q    <= cmd_beats;
        beat_idx_q <= 3'd0;
        if (cmd_write) wbuf_q <= wd_data;
      end

      if (adv && h_write) h_wdata <= wbuf_q;
      if (seq_take)       wbuf_q  <= wd_data;

      if (adv_mid) begin
        h_addr     <= next_addr;
        beat_idx_q <= beat_idx_q + 3'd1;
        trans_q    <= (h_write && !wd_valid) ? HT_BUSY : HT_SEQ;
      end
      if (busy_now && wd_valid) trans_q <= HT_SEQ;
      if (adv_last || cancel)   trans_q <= HT_IDLE;

      if (abort || ((state_q == ST_LAST) && h_ready)) begin
        trans_q <= HT_IDLE;
        h_sel   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_engine.sv
// Directed self-checking bench for ahb_lite_master_engine.
// Build with AHBM_WRAP_EN defined to exercise the WRAP4 branch.
module tb_ahb_lite_master_engine;

  logic        h_clk, h_rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_burst;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rd_valid, rd_err, done, done_err;
  logic [31:0] rd_data;
  logic        h_sel, h_write;
  logic [31:0] h_addr, h_wdata, h_rdata;
  logic [1:0]  h_trans, h_resp;
  logic [2:0]  h_burst, h_size;
  logic        h_ready;
  logic [31:0] slv_addr;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_lite_master_engine dut (
    .h_clk(h_clk), .h_rstn(h_rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(wd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .done(done), .done_err(done_err),
    .h_sel(h_sel), .h_addr(h_addr), .h_trans(h_trans), .h_write(h_write),
    .h_burst(h_burst), .h_size(h_size), .h_wdata(h_wdata),
    .h_ready(h_ready), .h_resp(h_resp), .h_rdata(h_rdata)
  );

  initial h_clk = 1'b0;
  always #5 h_clk = ~h_clk;

  // Minimal slave: read data is the data-phase address plus 0x1000_0000.
  always @(posedge h_clk or negedge h_rstn) begin
    if (!h_rstn)                  slv_addr <= 32'h0;
    else if (h_ready && h_trans[1]) slv_addr <= h_addr;
  end
  assign h_rdata = slv_addr + 32'h1000_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge h_clk);
    #1;
  endtask

  task automatic put_cmd(input logic w, input logic [31:0] a, input logic [2:0] b);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_burst = b;
  endtask

  initial begin
    h_rstn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_burst = 3'b000; wd_valid = 1'b0; wd_data = 32'h0; h_ready = 1'b1;
    h_resp = 2'b00;
    #3;
    // Reset values
    chk("rst_htrans", {30'd0, h_trans}, 32'd0);
    chk("rst_hsel", {31'd0, h_sel}, 32'd0);
    chk("rst_haddr", h_addr, 32'd0);
    chk("rst_hsize", {29'd0, h_size}, 32'd2);
    chk("rst_hwdata", h_wdata, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_done", {30'd0, done, done_err}, 32'd0);
    chk("rst_rd", {30'd0, rd_valid, rd_err}, 32'd0);
    cmd_valid = 1'b0;
    @(posedge h_clk); @(posedge h_clk); #1 h_rstn = 1'b1;
    tick();
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Write SINGLE 0x00
    put_cmd(1'b1, 32'h0, 3'b000); wd_valid = 1'b1; wd_data = 32'h0000_0051;
    #1;
    chk("ws_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("ws_wd_ready", {31'd0, wd_ready}, 32'd1);
    tick(); cmd_valid = 1'b0; wd_valid = 1'b0;
    chk("ws_c1_htrans", {30'd0, h_trans}, 32'd2);
    chk("ws_c1_haddr", h_addr, 32'h0);
    chk("ws_c1_ctl", {29'd0, h_sel, h_write, h_burst == 3'b000}, 32'd7);
    tick();
    chk("ws_c2_htrans", {30'd0, h_trans}, 32'd0);
    chk("ws_c2_hwdata", h_wdata, 32'h0000_0051);
    chk("ws_c2_done", {31'd0, done}, 32'd0);
    tick(); cmd_write = 1'b0;
    #1;
    chk("ws_c3_done", {30'd0, done, done_err}, 32'd2);
    chk("ws_c3_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("ws_c4_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("ws_c4_done", {31'd0, done}, 32'd0);

    // Read INCR4 at 0x2000_0000, no wait states
    put_cmd(1'b0, 32'h2000_0000, 3'b011);
    #1;
    chk("ri4_wd_ready", {31'd0, wd_ready}, 32'd0);
    tick(); cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ri4_htrans", {30'd0, h_trans}, (i == 0) ? 32'd2 : 32'd3);
      chk("ri4_haddr", h_addr, 32'h2000_0000 + 32'(4 * i));
      if (i >= 2) begin
        chk("ri4_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("ri4_rd_data", rd_data, 32'h3000_0000 + 32'(4 * (i - 2)));
      end else begin
        chk("ri4_rd_idle", {31'd0, rd_valid}, 32'd0);
      end
      tick();
    end
    chk("ri4_c5_htrans", {30'd0, h_trans}, 32'd0);
    chk("ri4_c5_rd_data", rd_data, 32'h3000_0008);
    chk("ri4_c5_done", {31'd0, done}, 32'd0);
    tick();
    chk("ri4_c6_rd", {31'd0, rd_valid}, 32'd1);
    chk("ri4_c6_rd_data", rd_data, 32'h3000_000C);
    chk("ri4_c6_done", {29'd0, done, done_err, rd_err}, 32'd4);
    tick();
    chk("ri4_c7_quiet", {30'd0, rd_valid, done}, 32'd0);

    // Write INCR4 with wd_valid low for two cycles after beat 1
    put_cmd(1'b1, 32'h0, 3'b011); wd_valid = 1'b1; wd_data = 32'hCAFE_00A0;
    #1;
    chk("wi4_wd_ready0", {31'd0, wd_ready}, 32'd1);
    tick(); cmd_valid = 1'b0; wd_data = 32'hCAFE_00A1;
    #1;
    chk("wi4_c1_htrans", {30'd0, h_trans}, 32'd2);
    chk("wi4_c1_wd_ready", {31'd0, wd_ready}, 32'd1);
    tick(); wd_valid = 1'b0;
    #1;
    chk("wi4_c2_htrans", {30'd0, h_trans}, 32'd3);
    chk("wi4_c2_haddr", h_addr, 32'h04);
    chk("wi4_c2_hwdata", h_wdata, 32'hCAFE_00A0);
    chk("wi4_c2_wd_ready", {31'd0, wd_ready}, 32'd0);
    tick();
    chk("wi4_c3_htrans", {30'd0, h_trans}, 32'd1);
    chk("wi4_c3_haddr", h_addr, 32'h08);
    chk("wi4_c3_hwdata", h_wdata, 32'hCAFE_00A1);
    tick(); wd_valid = 1'b1; wd_data = 32'hCAFE_00A2;
    #1;
    chk("wi4_c4_htrans", {30'd0, h_trans}, 32'd1);
    chk("wi4_c4_haddr", h_addr, 32'h08);
    chk("wi4_c4_wd_ready", {31'd0, wd_ready}, 32'd1);
    tick(); wd_data = 32'hCAFE_00A3;
    chk("wi4_c5_htrans", {30'd0, h_trans}, 32'd3);
    chk("wi4_c5_haddr", h_addr, 32'h08);
    tick(); wd_valid = 1'b0;
    chk("wi4_c6_haddr", h_addr, 32'h0C);
    chk("wi4_c6_hwdata", h_wdata, 32'hCAFE_00A2);
    tick();
    chk("wi4_c7_htrans", {30'd0, h_trans}, 32'd0);
    chk("wi4_c7_hwdata", h_wdata, 32'hCAFE_00A3);
    tick();
    chk("wi4_c8_done", {30'd0, done, done_err}, 32'd2);
    tick();

    // Read INCR8 at 0x2000_0040, three wait states on beat 3
    put_cmd(1'b0, 32'h2000_0040, 3'b101);
    tick(); cmd_valid = 1'b0;
    chk("ri8_c1_htrans", {30'd0, h_trans}, 32'd2);
    chk("ri8_c1_hburst", {29'd0, h_burst}, 32'd5);
    tick(); tick(); tick();
    chk("ri8_c4_haddr", h_addr, 32'h2000_004C);
    chk("ri8_c4_rd_data", rd_data, 32'h3000_0044);
    tick(); h_ready = 1'b0;
    chk("ri8_c5_rd_data", rd_data, 32'h3000_0048);
    for (int i = 0; i < 4; i++) begin
      chk("ri8_wait_htrans", {30'd0, h_trans}, 32'd3);
      chk("ri8_wait_haddr", h_addr, 32'h2000_0050);
      if (i > 0) chk("ri8_wait_rd", {31'd0, rd_valid}, 32'd0);
      if (i == 3) h_ready = 1'b1;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      chk("ri8_tail_rd", {31'd0, rd_valid}, 32'd1);
      chk("ri8_tail_rd_data", rd_data, 32'h3000_004C + 32'(4 * i));
      if (i == 3) chk("ri8_c12_htrans", {30'd0, h_trans}, 32'd0);
      if (i < 4) tick();
    end
    chk("ri8_c13_done", {30'd0, done, done_err}, 32'd2);
    tick();

    // Read INCR4 at 0x100 with an error response on beat 0
    put_cmd(1'b0, 32'h0000_0100, 3'b011);
    tick(); cmd_valid = 1'b0;
    chk("err_c1_htrans", {30'd0, h_trans}, 32'd2);
    tick(); h_ready = 1'b0; h_resp = 2'b10;
    chk("err_c2_htrans", {30'd0, h_trans}, 32'd3);
    tick(); h_ready = 1'b1;
    chk("err_c3_htrans", {30'd0, h_trans}, 32'd0);
    chk("err_c3_rd", {31'd0, rd_valid}, 32'd0);
    tick(); h_resp = 2'b00;
    chk("err_c4_rd", {30'd0, rd_valid, rd_err}, 32'd3);
    chk("err_c4_rd_data", rd_data, 32'h1000_0100);
    chk("err_c4_done", {30'd0, done, done_err}, 32'd3);
    chk("err_c4_bus", {29'd0, h_sel, h_trans}, 32'd0);
    tick();
    chk("err_c5_quiet", {28'd0, rd_valid, done, h_trans}, 32'd0);
    tick();
    chk("err_c6_htrans", {30'd0, h_trans}, 32'd0);

    // Unsupported INCR code is rejected without bus activity
    put_cmd(1'b0, 32'h2000_0000, 3'b001);
    #1;
    chk("rej_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick(); cmd_valid = 1'b0;
    #1;
    chk("rej_done", {30'd0, done, done_err}, 32'd3);
    chk("rej_bus", {29'd0, h_sel, h_trans}, 32'd0);
    chk("rej_cmd_ready_done", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("rej_after", {30'd0, done, cmd_ready}, 32'd1);

    // WRAP4 read at 0x2000_0018
    put_cmd(1'b0, 32'h2000_0018, 3'b010);
    tick(); cmd_valid = 1'b0;
`ifdef AHBM_WRAP_EN
    chk("wr4_hburst", {29'd0, h_burst}, 32'd2);
    chk("wr4_a0", h_addr, 32'h2000_0018);
    tick();
    chk("wr4_a1", h_addr, 32'h2000_001C);
    tick();
    chk("wr4_a2", h_addr, 32'h2000_0010);
    chk("wr4_rd0", rd_data, 32'h3000_0018);
    tick();
    chk("wr4_a3", h_addr, 32'h2000_0014);
    chk("wr4_a3_htrans", {30'd0, h_trans}, 32'd3);
    tick();
    chk("wr4_rd2", rd_data, 32'h3000_0010);
    tick();
    chk("wr4_rd3", rd_data, 32'h3000_0014);
    chk("wr4_done", {30'd0, done, done_err}, 32'd2);
    tick();
`else
    chk("wr4_rej_done", {30'd0, done, done_err}, 32'd3);
    chk("wr4_rej_bus", {29'd0, h_sel, h_trans}, 32'd0);
    tick();
`endif

    // Reset in the middle of a burst abandons it
    put_cmd(1'b0, 32'h2000_0000, 3'b011);
    tick(); cmd_valid = 1'b0;
    tick();
    chk("mrst_pre_htrans", {30'd0, h_trans}, 32'd3);
    h_rstn = 1'b0;
    #1;
    chk("mrst_bus", {29'd0, h_sel, h_trans}, 32'd0);
    chk("mrst_haddr", h_addr, 32'd0);
    tick();
    chk("mrst_quiet", {30'd0, rd_valid, done}, 32'd0);
    h_rstn = 1'b1;
    tick();
    chk("mrst_after", {29'd0, cmd_ready, h_trans}, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
